imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words and issues one-cycle word writes into the instruction memory's write port.
- Sits between the host/UART byte source and the instruction memory.
- The CPU holds fetch while busy is high.
- Addresses produced are byte addresses. The memory indexes them with waddr[31:2], matching the fetch-side read indexing.

Parameters:
- DEPTH, 1024, number of 32-bit words in instruction memory
- LEN_W, 11, width of load_len (must hold DEPTH)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load; sampled in IDLE only
- base_addr  in  32  byte address of first word; bits [1:0] ignored (treated as 0)
- load_len  in  LEN_W  number of words to load
- in_valid  in  1  byte source has data
- in_data  in  8  byte payload
- in_ready  out  1  loader can accept a byte this cycle
- wen  out  1  write strobe to instruction memory, one cycle per word
- waddr  out  32  byte address of write
- wdata  out  32  assembled word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- err  out  1  sticky error flag; cleared by next accepted start or by rst

Behaviour:
- Reset (async, rst=1): state=IDLE. in_ready=0, wen=0, waddr=0, wdata=0, busy=0, done=0, err=0. Byte counter, word counter and assembly register are cleared.
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1, latch base_addr (with [1:0] forced to 0) and load_len, clear err, set word_idx=0 and byte_idx=0.
  - If load_len==0: go to FINISH.
  - If load_len>DEPTH: set err=1 and go to FINISH. No writes occur.
  - Otherwise: go to COLLECT.
- COLLECT:
  - in_ready=1, busy=1.
  - A byte is accepted when in_valid and in_ready are both 1 on a clock edge.
  - Byte k (k=0..3) goes to asm[8k+7:8k]; byte_idx increments.
  - On acceptance of byte 3, go to WRITE. The assembled word is presented next cycle.
  - in_valid without in_ready never consumes data.
- WRITE:
  - Lasts exactly one cycle.
  - wen=1, waddr=base+4*word_idx (32-bit wrap-around allowed), wdata=asm, in_ready=0.
  - Next cycle: word_idx increments and byte_idx is cleared. If word_idx+1==load_len, go to FINISH; else go to COLLECT.
- FINISH:
  - done=1 for exactly one cycle, busy=0; then IDLE.
- Latency: the 4th byte is accepted at edge N; wen is high during cycle N+1; the next byte can be accepted at edge N+2.
- Minimum per word: 5 cycles.
- wen, waddr and wdata are registered outputs.
- waddr and wdata hold their last values when wen=0.
- start asserted while not in IDLE is ignored.
- Reset mid-operation aborts immediately. Already-written words remain in memory; no partial word is written.
- in_valid deasserted mid-word stalls COLLECT indefinitely. There is no timeout.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, the loader stays in COLLECT for 4 more bytes forming a little-endian checksum word. This word is not written (no wen).
  - The loader keeps a running 32-bit XOR of all written words, reset at start.
  - In FINISH, err=1 if checksum != running XOR.
  - done still pulses.
- When undefined: no trailing word is consumed and err is only the length error.

Test Plan:
- Reset, then start with base=0, len=3, bytes 13 03 40 06 93 03 40 01 33 0E 73 00 streamed back-to-back:
  - Writes (0,0x06400313), (4,0x01400393), (8,0x00730E33), each wen one cycle.
  - done pulses once; busy is low afterwards.
- base=0x103 (low bits ignored), len=1, in_valid toggled 1/0 every cycle with bytes AA BB CC DD:
  - Single write waddr=0x100, wdata=0xDDCCBBAA.
  - in_ready is low during the WRITE cycle.
- Length boundaries:
  - len=0: done in the cycle after start, no wen, err=0.
  - len=DEPTH+1: no wen, err=1, done pulses.
  - Next start with len=1 clears err.
- Assert rst after 6 bytes of a len=2 load:
  - All outputs return to reset values asynchronously.
  - Exactly one wen occurred (word 0); bytes 4-5 are never written.
- start pulsed during COLLECT with different base:
  - Ignored; addresses continue from the original base.
- With IMEM_LOADER_CHECKSUM_EN defined, len=2, words 0x11111111 and 0x22222222:
  - Trailing 0x33333333 gives err=0.
  - Trailing 0x33333334 gives err=1.
  - In both cases exactly two wen occur.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: little-endian byte stream to 32-bit instruction memory word writes (IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word)
module imem_loader #(
   parameter int DEPTH = 1024,
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] load_len,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             wen,
   output logic [31:0]      waddr,
   output logic [31:0]      wdata,
   output logic             busy,
   output logic             done,
   output logic             err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic CK_EN = 1'b1;
`else
   localparam logic CK_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;
   state_t r_state, w_next;
   logic [31:0] r_addr, r_xor, r_waddr, r_wdata, w_word;
   logic [23:0] r_asm;
   logic [LEN_W-1:0] r_len, r_word_idx;
   logic [1:0] r_byte_idx;
   logic r_ck, r_wen, r_err, w_accept, w_len_bad, w_last_word;
   assign w_accept = in_valid && r_state == COLLECT;
   assign w_len_bad = load_len > LEN_W'(DEPTH);
   assign w_last_word = r_word_idx + LEN_W'(1) == r_len;
   // bytes 0..2 shift in from the top so the 4th byte completes the word directly
   assign w_word = {in_data, r_asm};
   assign wen = r_wen;
   assign waddr = r_waddr;
   assign wdata = r_wdata;
   assign err = r_err;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      in_ready = r_state == COLLECT;
      busy = r_state == COLLECT || r_state == WRITE;
      done = r_state == FINISH;
      case (r_state)
         IDLE:    if (start) w_next = (load_len == '0 || w_len_bad) ? FINISH : COLLECT;
         COLLECT: if (w_accept && r_byte_idx == 2'd3) w_next = r_ck ? FINISH : WRITE;
         WRITE:   w_next = (w_last_word && !CK_EN) ? FINISH : COLLECT;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_addr <= '0;
         r_xor <= '0;
         r_asm <= '0;
         r_len <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_ck <= 1'b0;
         r_wen <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_err <= 1'b0;
      end else begin
         r_wen <= 1'b0;
         if (r_state == IDLE && start) begin
            r_addr <= base_addr & ~32'd3;
            r_len <= load_len;
            r_err <= w_len_bad;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_ck <= 1'b0;
            r_xor <= '0;
         end
         if (w_accept) begin
            r_asm <= {in_data, r_asm[23:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3 && r_ck) r_err <= w_word != r_xor;
            if (r_byte_idx == 2'd3 && !r_ck) begin
               r_wen <= 1'b1;
               r_waddr <= r_addr;
               r_wdata <= w_word;
               r_xor <= r_xor ^ w_word;
            end
         end
         if (r_state == WRITE) begin
            r_word_idx <= r_word_idx + LEN_W'(1);
            r_byte_idx <= '0;
            r_addr <= r_addr + 32'd4;
            r_ck <= CK_EN && w_last_word;
         end
      end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a word-level reference model
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   logic clk = 0, rst = 1, start = 0, in_valid = 0;
   logic [31:0] base_addr = 0;
   logic [10:0] load_len = 0;
   logic [7:0] in_data = 0;
   logic in_ready, wen, busy, done, err;
   logic [31:0] waddr, wdata;
   logic [31:0] wa_q[$], wd_q[$], exp_a[$], exp_d[$];
   int wc_q[$];
   int cyc = 0, done_cnt = 0, wen_dbl = 0, rdy_viol = 0, n_tests = 0, n_fail = 0;
   logic wen_prev = 0;

   imem_loader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .load_len(load_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wen(wen),
      .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (wen) begin
         wa_q.push_back(waddr);
         wd_q.push_back(wdata);
         wc_q.push_back(cyc);
      end
      if (wen && wen_prev) wen_dbl <= wen_dbl + 1;
      if (wen && in_ready) rdy_viol <= rdy_viol + 1;
      if (done) done_cnt <= done_cnt + 1;
      wen_prev <= wen;
   end

   function automatic void model(input logic [31:0] b, input int len, input logic [7:0] q[$]);
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < len; i++) begin
         exp_a.push_back((b - (b % 4)) + 32'(4 * i));
         exp_d.push_back({q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]});
      end
   endfunction

   task automatic do_start(input logic [31:0] b, input int len);
      @(negedge clk);
      start = 1;
      base_addr = b;
      load_len = 11'(len);
      @(posedge clk);
      #1 start = 0;
   endtask

   // mode 0: valid always high, 1: toggles every cycle, 2: random
   task automatic send(input logic [7:0] q[$], input int mode);
      int idx = 0, t = 0;
      bit ph = 1, acc;
      while (idx < q.size() && t < 2000) begin
         @(negedge clk);
         t++;
         in_valid = mode == 0 ? 1'b1 : mode == 1 ? ph : ($urandom_range(0, 2) != 0);
         ph = !ph;
         in_data = in_valid ? q[idx] : 8'($urandom);
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) idx++;
      end
      #1 in_valid = 0;
      if (idx < q.size()) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout got %0d bytes exp %0d", idx, q.size());
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      if (n == 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout got no done exp done within 200 cycles");
      end
   endtask

   task automatic run_load(input logic [31:0] b, input int len, input logic [7:0] q[$], input int mode, output int n);
      logic [7:0] qq[$];
      logic [31:0] x = 0;
      qq = q;
      if (CK && len > 0 && len <= 1024) begin
         for (int i = 0; i < len; i++) x ^= {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
         for (int i = 0; i < 4; i++) qq.push_back(8'(x >> (8 * i)));
      end
      do_start(b, len);
      send(qq, mode);
      wait_done(n);
   endtask

   task automatic test_reset;
      rst = 1;
      #12;
      n_tests++;
      if ({in_ready, wen, waddr, wdata, busy, done, err} !== 69'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got %h exp 0", {in_ready, wen, waddr, wdata, busy, done, err});
      end
      @(negedge clk) rst = 0;
   endtask

   task automatic test_basic;
      logic [7:0] q[$] = '{8'h13, 8'h03, 8'h40, 8'h06, 8'h93, 8'h03, 8'h40, 8'h01, 8'h33, 8'h0E, 8'h73, 8'h00};
      logic [31:0] ea[3] = '{32'h0, 32'h4, 32'h8};
      logic [31:0] ed[3] = '{32'h06400313, 32'h01400393, 32'h00730E33};
      int a0 = wa_q.size(), d0 = done_cnt, n;
      run_load(0, 3, q, 0, n);
      @(negedge clk);
      n_tests++;
      if (wa_q.size() - a0 != 3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", wa_q.size() - a0); end
      for (int i = 0; i < 3 && a0 + i < wa_q.size(); i++) begin
         n_tests++;
         if (wa_q[a0+i] !== ea[i] || wd_q[a0+i] !== ed[i]) begin
            n_fail++;
            $display("FAIL basic_write%0d got %h/%h exp %h/%h", i, wa_q[a0+i], wd_q[a0+i], ea[i], ed[i]);
         end
      end
      for (int i = 1; i < 3 && a0 + i < wc_q.size(); i++) begin
         n_tests++;
         if (wc_q[a0+i] - wc_q[a0+i-1] != 5) begin
            n_fail++;
            $display("FAIL basic_spacing%0d got %0d exp 5", i, wc_q[a0+i] - wc_q[a0+i-1]);
         end
      end
      n_tests++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done got done=%0d busy=%b exp done=1 busy=0", done_cnt - d0, busy);
      end
   endtask

   task automatic test_toggle;
      logic [7:0] q[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      int a0 = wa_q.size(), r0 = rdy_viol, n;
      run_load(32'h103, 1, q, 1, n);
      @(negedge clk);
      n_tests++;
      if (wa_q.size() - a0 != 1) begin n_fail++; $display("FAIL toggle_count got %0d exp 1", wa_q.size() - a0); end
      else begin
         n_tests++;
         if (wa_q[a0] !== 32'h100 || wd_q[a0] !== 32'hDDCCBBAA) begin
            n_fail++;
            $display("FAIL toggle_write got %h/%h exp 00000100/ddccbbaa", wa_q[a0], wd_q[a0]);
         end
      end
      n_tests++;
      if (rdy_viol != r0) begin n_fail++; $display("FAIL toggle_ready_in_write got %0d exp 0", rdy_viol - r0); end
   endtask

   task automatic test_len_bounds;
      logic [7:0] q[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
      int a0 = wa_q.size(), d0 = done_cnt, n;
      do_start(32'h10, 0);
      wait_done(n);
      n_tests++;
      if (n != 0 || err !== 1'b0) begin n_fail++; $display("FAIL len0 got lat=%0d err=%b exp lat=0 err=0", n, err); end
      do_start(32'h10, 1025);
      wait_done(n);
      n_tests++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL lenbig_err got %b exp 1", err); end
      @(negedge clk);
      n_tests++;
      if (wa_q.size() != a0 || done_cnt - d0 != 2 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL lenbig_after got wen=%0d done=%0d err=%b exp 0/2/1", wa_q.size() - a0, done_cnt - d0, err);
      end
      do_start(32'h20, 1);
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
      run_load(32'h20, 1, q, 0, n);
      @(negedge clk);
      n_tests++;
      if (wa_q.size() - a0 != 1) begin n_fail++; $display("FAIL len1_count got %0d exp 1", wa_q.size() - a0); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] q[$];
      int a0 = wa_q.size();
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(1, 255)));
      do_start(32'h300, 2);
      send(q, 0);
      #1 rst = 1;
      #1;
      n_tests++;
      if ({in_ready, wen, waddr, wdata, busy, done, err} !== 69'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs got %h exp 0", {in_ready, wen, waddr, wdata, busy, done, err});
      end
      @(negedge clk) rst = 0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (wa_q.size() - a0 != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_writes got %0d busy=%b exp 1 busy=0", wa_q.size() - a0, busy);
      end
      else begin
         n_tests++;
         if (wa_q[a0] !== 32'h300 || wd_q[a0] !== {q[3], q[2], q[1], q[0]}) begin
            n_fail++;
            $display("FAIL rst_mid_word0 got %h/%h exp 00000300/%h", wa_q[a0], wd_q[a0], {q[3], q[2], q[1], q[0]});
         end
      end
   endtask

   task automatic test_start_ignored;
      logic [7:0] q[$];
      logic [31:0] x = 0;
      int a0 = wa_q.size(), d0 = done_cnt, n;
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      model(32'h40, 2, q);
      if (CK) begin
         x = exp_d[0] ^ exp_d[1];
         for (int i = 0; i < 4; i++) q.push_back(8'(x >> (8 * i)));
      end
      do_start(32'h40, 2);
      send(q[0:2], 0);
      do_start(32'h800, 7);
      send(q[3:$], 0);
      wait_done(n);
      @(negedge clk);
      n_tests++;
      if (wa_q.size() - a0 != 2 || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL ign_count got wen=%0d done=%0d exp 2/1", wa_q.size() - a0, done_cnt - d0);
      end
      for (int i = 0; i < 2 && a0 + i < wa_q.size(); i++) begin
         n_tests++;
         if (wa_q[a0+i] !== exp_a[i] || wd_q[a0+i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL ign_write%0d got %h/%h exp %h/%h", i, wa_q[a0+i], wd_q[a0+i], exp_a[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 6; it++) begin
         logic [7:0] q[$];
         logic [31:0] b = $urandom;
         int len = $urandom_range(1, 4), a0 = wa_q.size(), d0 = done_cnt, n;
         for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
         model(b, len, q);
         run_load(b, len, q, 2, n);
         @(negedge clk);
         n_tests++;
         if (wa_q.size() - a0 != len || done_cnt - d0 != 1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_count got wen=%0d done=%0d err=%b exp %0d/1/0", it, wa_q.size() - a0, done_cnt - d0, err, len);
         end
         for (int i = 0; i < len && a0 + i < wa_q.size(); i++) begin
            n_tests++;
            if (wa_q[a0+i] !== exp_a[i] || wd_q[a0+i] !== exp_d[i]) begin
               n_fail++;
               $display("FAIL rand%0d_write%0d got %h/%h exp %h/%h", it, i, wa_q[a0+i], wd_q[a0+i], exp_a[i], exp_d[i]);
            end
         end
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      for (int k = 0; k < 2; k++) begin
         logic [7:0] q[$] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33};
         int a0 = wa_q.size(), n;
         if (k == 1) q[8] = 8'h34;
         do_start(32'h0, 2);
         send(q, 0);
         wait_done(n);
         n_tests++;
         if (err !== 1'(k)) begin n_fail++; $display("FAIL csum%0d_err got %b exp %0d", k, err, k); end
         @(negedge clk);
         n_tests++;
         if (wa_q.size() - a0 != 2) begin n_fail++; $display("FAIL csum%0d_count got %0d exp 2", k, wa_q.size() - a0); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_len_bounds();
      test_reset_mid();
      test_start_ignored();
      test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      n_tests++;
      if (wen_dbl != 0) begin n_fail++; $display("FAIL wen_width got %0d multi-cycle strobes exp 0", wen_dbl); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
